// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

    localparam int unsigned KP_COLS   = 4;
    localparam int unsigned KP_ROWS   = 4;
    localparam int unsigned KP_CODE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } kp_state_t;

    typedef enum logic [1:0] {
        SCAN_NONE,
        SCAN_SINGLE,
        SCAN_MULTI
    } kp_kind_t;

    // Pressed-key count saturating at 2; only 0 / 1 / many matter.
    function automatic logic [1:0] kp_count_sat(input logic [1:0] acc,
                                                input logic [KP_ROWS-1:0] hits);
        int unsigned n;
        n = 32'(acc) + 32'($countones(hits));
        return (n >= 32'd2) ? 2'd2 : 2'(n);
    endfunction

    // Highest pressed row index within one column sample.
    function automatic logic [1:0] kp_last_row(input logic [KP_ROWS-1:0] hits);
        logic [1:0] idx;
        idx = 2'd0;
        for (int unsigned r = 0; r < KP_ROWS; r++) begin
            if (hits[r]) idx = 2'(r);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scan.sv
// Row synchronizer, column strobe rotation and per-scan key accumulation.
// Scan-result outputs (_c) are combinational and valid on the col-3 sample cycle.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [KP_ROWS-1:0]   i_row,
    output logic [KP_COLS-1:0]   o_col_sel,
    output logic                 o_scan_done_c,
    output kp_kind_t             o_scan_kind_c,
    output logic [KP_CODE_W-1:0] o_scan_code_c
);

    localparam int unsigned PW    = $clog2(SCAN_DIV);
    localparam int unsigned COL_W = $clog2(KP_COLS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    logic [KP_ROWS-1:0]   r_row_meta;
    logic [KP_ROWS-1:0]   r_row_sync;
    logic [PW-1:0]        r_presc;
    logic [COL_W-1:0]     r_col;
    logic [KP_COLS-1:0]   r_col_sel;
    logic [1:0]           r_acc;
    logic [KP_CODE_W-1:0] r_acc_code;

    logic [KP_ROWS-1:0]   w_pressed;
    logic                 w_sample;
    logic                 w_first_col;
    logic [1:0]           w_tot;
    logic [KP_CODE_W-1:0] w_code;

    assign w_pressed   = ~r_row_sync;
    assign w_sample    = (r_presc == PRESC_LAST);
    assign w_first_col = (r_col == COL_W'(0));

    // Column 0 restarts the accumulation so no clear cycle is needed at wrap.
    assign w_tot  = kp_count_sat(w_first_col ? 2'd0 : r_acc, w_pressed);
    assign w_code = (|w_pressed) ? {r_col, kp_last_row(w_pressed)}
                                 : (w_first_col ? KP_CODE_W'(0) : r_acc_code);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row_meta <= '1;
            r_row_sync <= '1;
            r_presc    <= '0;
            r_col      <= '0;
            r_col_sel  <= 4'b1110;
            r_acc      <= '0;
            r_acc_code <= '0;
        end else begin
            r_row_meta <= i_row;
            r_row_sync <= r_row_meta;
            if (w_sample) begin
                r_presc    <= '0;
                r_col      <= r_col + COL_W'(1);
                r_col_sel  <= {r_col_sel[KP_COLS-2:0], r_col_sel[KP_COLS-1]};
                r_acc      <= w_tot;
                r_acc_code <= w_code;
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    assign o_col_sel     = r_col_sel;
    assign o_scan_done_c = w_sample && (r_col == COL_W'(KP_COLS - 1));
    assign o_scan_code_c = w_code;
    assign o_scan_kind_c = (w_tot == 2'd0) ? SCAN_NONE :
                           (w_tot == 2'd1) ? SCAN_SINGLE : SCAN_MULTI;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: per-scan debounce FSM with registered key event outputs.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 100_000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [KP_ROWS-1:0]   row,
    output logic [KP_COLS-1:0]   col_sel,
    output logic [KP_CODE_W-1:0] key_code,
    output logic                 key_valid,
    output logic                 key_pressed
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] DB_TARGET = CNT_W'(DEBOUNCE_SCANS);

    logic                 w_scan_done;
    kp_kind_t             w_scan_kind;
    logic [KP_CODE_W-1:0] w_scan_code;
    logic                 w_same_key;
    logic                 w_none;
    logic [CNT_W-1:0]     w_cnt_inc;

    kp_state_t            r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [KP_CODE_W-1:0] r_cand;
    logic [KP_CODE_W-1:0] r_key_code;
    logic                 r_key_valid;
    logic                 r_key_pressed;

    keypad_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk           (clk),
        .reset         (reset),
        .i_row         (row),
        .o_col_sel     (col_sel),
        .o_scan_done_c (w_scan_done),
        .o_scan_kind_c (w_scan_kind),
        .o_scan_code_c (w_scan_code)
    );

    assign w_same_key = (w_scan_kind == SCAN_SINGLE) && (w_scan_code == r_cand);
    assign w_none     = (w_scan_kind == SCAN_NONE);
    assign w_cnt_inc  = r_cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_cand        <= '0;
            r_key_code    <= '0;
            r_key_valid   <= 1'b0;
            r_key_pressed <= 1'b0;
        end else begin
            r_key_valid <= 1'b0;
            if (w_scan_done) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_scan_kind == SCAN_SINGLE) begin
                            r_cand <= w_scan_code;
                            if (DB_TARGET == CNT_W'(1)) begin
                                r_state       <= ST_PRESSED;
                                r_cnt         <= '0;
                                r_key_code    <= w_scan_code;
                                r_key_valid   <= 1'b1;
                                r_key_pressed <= 1'b1;
                            end else begin
                                r_state <= ST_DEBOUNCE;
                                r_cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    ST_DEBOUNCE: begin
                        if (w_same_key) begin
                            r_cnt <= w_cnt_inc;
                            if (w_cnt_inc >= DB_TARGET) begin
                                r_state       <= ST_PRESSED;
                                r_cnt         <= '0;
                                r_key_code    <= r_cand;
                                r_key_valid   <= 1'b1;
                                r_key_pressed <= 1'b1;
                            end
                        end else begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end
                    end
                    ST_PRESSED: begin
                        // A single empty scan already completes a 1-scan release.
                        if (!w_same_key) begin
                            if (w_none && DB_TARGET == CNT_W'(1)) begin
                                r_state       <= ST_IDLE;
                                r_cnt         <= '0;
                                r_key_pressed <= 1'b0;
                            end else begin
                                r_state <= ST_RELEASE;
                                r_cnt   <= w_none ? CNT_W'(1) : CNT_W'(0);
                            end
                        end
                    end
                    ST_RELEASE: begin
                        if (w_same_key) begin
                            r_state <= ST_PRESSED;
                            r_cnt   <= '0;
                        end else if (w_none) begin
                            if (w_cnt_inc >= DB_TARGET) begin
                                r_state       <= ST_IDLE;
                                r_cnt         <= '0;
                                r_key_pressed <= 1'b0;
                            end else begin
                                r_cnt <= w_cnt_inc;
                            end
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign key_pressed = r_key_pressed;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and randomized keypad scenarios checked against a per-scan debounce model.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 8;
    localparam int DS       = 3;
    localparam int SCAN     = 4 * SCAN_DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row;
    logic [3:0]  col_sel;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_pressed;
    logic [15:0] keys;

    int checks = 0;
    int errors = 0;

    // Reference model state: keys are indexed by code {col,row}.
    bit         m_pressed;
    bit         m_pulse;
    int         m_run;
    int         m_quiet;
    logic [3:0] m_cand;
    logic [3:0] m_code;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .row         (row),
        .col_sel     (col_sel),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_pressed (key_pressed)
    );

    // Physical keypad: a held key pulls its row low while its column is strobed.
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (col_sel[c] == 1'b0) row = ~keys[c*4 +: 4];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pressed = 1'b0;
        m_pulse   = 1'b0;
        m_run     = 0;
        m_quiet   = 0;
        m_cand    = 4'h0;
        m_code    = 4'h0;
    endtask

    task automatic model_scan(input logic [15:0] k);
        int         n;
        logic [3:0] idx;
        n   = $countones(k);
        idx = 4'h0;
        for (int i = 0; i < 16; i++) if (k[i]) idx = 4'(i);
        m_pulse = 1'b0;
        if (!m_pressed) begin
            if (n == 1 && (m_run == 0 || idx == m_cand)) begin
                if (m_run == 0) m_cand = idx;
                m_run++;
                if (m_run == DS) begin
                    m_pressed = 1'b1;
                    m_pulse   = 1'b1;
                    m_code    = m_cand;
                    m_run     = 0;
                    m_quiet   = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (n == 1 && idx == m_cand) begin
                m_quiet = 0;
            end else if (n == 0) begin
                m_quiet++;
                if (m_quiet == DS) begin
                    m_pressed = 1'b0;
                    m_quiet   = 0;
                    m_run     = 0;
                end
            end else begin
                m_quiet = 0;
            end
        end
    endtask

    // One full scan with a fixed key set; outputs are checked in the first cycle of the next scan.
    task automatic run_scan(input logic [15:0] k, input string tag);
        int         stray;
        int         colbad;
        int         c;
        logic [3:0] one;
        logic [3:0] exp_col;
        stray  = 0;
        colbad = 0;
        one    = 4'b0001;
        keys   = k;
        for (int i = 0; i < SCAN; i++) begin
            @(posedge clk);
            #1;
            c       = (i + 1) % SCAN;
            exp_col = ~(one << (c / SCAN_DIV));
            if (col_sel !== exp_col) colbad++;
            if (i < SCAN - 1 && key_valid !== 1'b0) stray++;
        end
        model_scan(k);
        check($sformatf("%s col_sel sequence", tag), 32'(colbad), 32'd0);
        check($sformatf("%s stray key_valid", tag), 32'(stray), 32'd0);
        check($sformatf("%s key_valid", tag), 32'(key_valid), 32'(m_pulse));
        check($sformatf("%s key_pressed", tag), 32'(key_pressed), 32'(m_pressed));
        check($sformatf("%s key_code", tag), 32'(key_code), 32'(m_code));
    endtask

    task automatic check_reset_values(input string tag);
        check($sformatf("%s col_sel", tag), 32'(col_sel), 32'h0000_000E);
        check($sformatf("%s key_code", tag), 32'(key_code), 32'd0);
        check($sformatf("%s key_valid", tag), 32'(key_valid), 32'd0);
        check($sformatf("%s key_pressed", tag), 32'(key_pressed), 32'd0);
    endtask

    initial begin
        logic [15:0] cur;
        int          r;

        keys  = 16'h0000;
        reset = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b0;

        // Free run with no keys: column rotation only.
        repeat (2) run_scan(16'h0000, "idle");

        // Clean hold of key 9 (col 2, row 1).
        repeat (14) run_scan(16'h0200, "hold9");

        // Release with a one-scan re-press in the middle.
        run_scan(16'h0000, "rel9_a");
        run_scan(16'h0200, "rel9_gap");
        repeat (4) run_scan(16'h0000, "rel9_b");

        // Key 5 bouncing, then stable, then released.
        repeat (2) begin
            run_scan(16'h0020, "bounce5_on");
            run_scan(16'h0000, "bounce5_off");
        end
        repeat (5) run_scan(16'h0020, "stable5");
        repeat (4) run_scan(16'h0000, "rel5");

        // Two keys together must never be accepted.
        repeat (10) run_scan(16'h8001, "multi");
        run_scan(16'h0000, "multi_rel");

        // Reset in the middle of a debounce, key still held.
        repeat (2) run_scan(16'h0200, "pre_reset9");
        repeat (12) @(posedge clk);
        #1;
        reset = 1'b1;
        #2;
        check_reset_values("mid_reset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) run_scan(16'h0200, "post_reset9");
        repeat (4) run_scan(16'h0000, "post_reset_rel");

        // Randomized key activity held for random stretches.
        cur = 16'h0000;
        for (int s = 0; s < 40; s++) begin
            r = int'($urandom_range(0, 99));
            if (r < 40) begin
                cur = cur;
            end else if (r < 60) begin
                cur = 16'h0000;
            end else if (r < 90) begin
                cur = 16'h0001 << $urandom_range(0, 15);
            end else begin
                cur = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            end
            run_scan(cur, "rand");
        end
        repeat (4) run_scan(16'h0000, "final_rel");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
